guess_responder: RTL and testbench
==================================

# guess_responder

Defending-side responder for the 28-cell Battleship board. It accepts one-hot guesses from a guess source such as the computer guess generator or the player-select logic, and checks each guess against the latched ship placement. It reports hit, miss or repeat per guess, accumulates hit and miss maps for the display, and flags game over when every ship cell has been hit.

## Interface
- CELLS, 28, number of board cells (bit i = cell i)
- CNT_W, 5, width of hit/ship counters (must hold CELLS)
- clk  in  1  game clock
- rst  in  1  reset rst, asynchronous, active-high; clock clk
- load_ships  in  1  latch ship_map (SETUP state only)
- ship_map  in  CELLS  ship placement, 1 = ship cell
- guess_valid  in  1  guess present
- guess  in  CELLS  guess vector, one-hot expected
- guess_ready  out  1  high only in READY
- result_valid  out  1  one-cycle pulse, result fields valid
- result_hit  out  1  guess hit a ship cell not previously guessed
- result_repeat  out  1  guess overlaps an already-guessed cell
- result_err  out  1  malformed guess (tied 0 without macro)
- hit_map  out  CELLS  cumulative hit cells
- miss_map  out  CELLS  cumulative miss cells
- hit_count  out  CNT_W  number of hit cells
- game_over  out  1  all ship cells hit

## Operation
- States: SETUP, READY, EVAL, RESP, OVER.
- SETUP: guess_ready=0. On load_ships with ship_map!=0: latch ships, ship_cnt=popcount(ship_map), go to READY. A load_ships with ship_map==0 is ignored; the block stays in SETUP. load_ships is ignored in all other states.
- READY: guess_ready=1. guess_valid&&guess_ready captures guess, go to EVAL.
- EVAL: known=hit_map|miss_map. Priority: err (macro) > repeat > normal.
  - repeat = |(guess & known): no map or count change, result_hit=0.
  - normal: hit_map |= guess&ships; miss_map |= guess&~ships; hit_count += popcount(guess&ships); result_hit = |(guess&ships).
  - guess==0 without macro: no change, all result flags 0.
  - Go to RESP.
- RESP: result_valid=1. If hit_count==ship_cnt go to OVER, else go to READY.
- OVER: game_over=1, guess_ready=0, maps frozen. Stays in OVER until rst.
- hit_count never exceeds ship_cnt. No wrap is possible, because cells are counted once.
- Result flags hold their value until the next EVAL. They are qualified only by result_valid.

## Timing
- Reset values: state SETUP; all outputs 0; ships, ship_cnt and internal registers 0.
- Acceptance edge E0 → EVAL. Edge E1 updates the maps, hit_count and flags; result_valid is high from E1 to E2. game_over rises at E2 when the final hit lands.
- Throughput is one guess per 3 cycles. guess_valid outside READY is ignored, not queued.
- rst mid-operation (any state) aborts immediately. Any in-flight guess is discarded with no result_valid. Ships must be reloaded afterwards.
- guess and ship_map are sampled only on their capture edges. They need not be held afterwards.

## Configuration
- GUESS_ONEHOT_CHECK_EN defined: in EVAL, a guess that is zero or has more than one bit set gives result_err=1, result_hit=0, result_repeat=0, and no state change except the result_valid pulse.
- Undefined: result_err is tied 0. Multi-bit guesses are processed bitwise as above; a zero guess returns all-zero flags.

## Test plan
- Load ship_map=28'h0000060, guess 1<<5 → result_hit=1, hit_map=28'h0000020, hit_count=1, game_over=0.
- Continue with guess 1<<16 → result_hit=0, miss_map=28'h0010000. Then guess 1<<6 → result_hit=1, hit_count=2, game_over=1 one cycle after result_valid, and guess_ready stays 0.
- Repeat guess 1<<16 after a miss → result_repeat=1, result_hit=0, maps and hit_count unchanged.
- Macro on: guess 28'h0000003 → result_err=1. guess 0 → result_err=1. Maps unchanged in both cases. Macro off: guess 28'h0000003 with ships at bit 0 → hit_map bit0 set, miss_map bit1 set, hit_count+1.
- load_ships with ship_map=0 → remains in SETUP, guess_ready=0. guess_valid pulses produce no result_valid.
- Assert rst during EVAL → next cycle all outputs 0, no result_valid, state SETUP, and a fresh load_ships is accepted.

Source files
------------

// File: rtl/guess_responder.sv
// Defending-side Battleship responder: scores one-hot guesses against latched ships.
// Optional GUESS_ONEHOT_CHECK_EN flags zero or multi-bit guesses as malformed.
module guess_responder #(
   parameter int CELLS = 28,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_ships,
   input  logic [CELLS-1:0] ship_map,
   input  logic             guess_valid,
   input  logic [CELLS-1:0] guess,
   output logic             guess_ready,
   output logic             result_valid,
   output logic             result_hit,
   output logic             result_repeat,
   output logic             result_err,
   output logic [CELLS-1:0] hit_map,
   output logic [CELLS-1:0] miss_map,
   output logic [CNT_W-1:0] hit_count,
   output logic             game_over
);

   typedef enum logic [2:0] {
      S_SETUP,
      S_READY,
      S_EVAL,
      S_RESP,
      S_OVER
   } state_t;

   state_t           state_q;
   logic [CELLS-1:0] ships_q;
   logic [CNT_W-1:0] ship_cnt_q;
   logic [CELLS-1:0] guess_q;
   logic [CELLS-1:0] hit_map_q;
   logic [CELLS-1:0] miss_map_q;
   logic [CNT_W-1:0] hit_cnt_q;
   logic             ready_q;
   logic             valid_q;
   logic             hit_q;
   logic             rep_q;
   logic             over_q;

   logic [CELLS-1:0] g_hit;
   logic [CELLS-1:0] g_miss;
   logic [CELLS-1:0] known;
   logic             is_rep;
   logic             bad_guess;

   function automatic logic [CNT_W-1:0] popcnt(input logic [CELLS-1:0] v);
      logic [CNT_W-1:0] s;
      s = '0;
      for (int i = 0; i < CELLS; i++) begin
         s = s + CNT_W'(v[i]);
      end
      return s;
   endfunction

   assign g_hit  = guess_q & ships_q;
   assign g_miss = guess_q & ~ships_q;
   assign known  = hit_map_q | miss_map_q;
   assign is_rep = |(guess_q & known);

`ifdef GUESS_ONEHOT_CHECK_EN
   logic err_q;

   // Zero, or two or more bits set (clearing the lowest set bit leaves something).
   assign bad_guess  = (guess_q == '0) ||
                       ((guess_q & (guess_q - CELLS'(1))) != '0);
   assign result_err = err_q;
`else
   assign bad_guess  = 1'b0;
   assign result_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_SETUP;
         ships_q    <= '0;
         ship_cnt_q <= '0;
         guess_q    <= '0;
         hit_map_q  <= '0;
         miss_map_q <= '0;
         hit_cnt_q  <= '0;
         ready_q    <= 1'b0;
         valid_q    <= 1'b0;
         hit_q      <= 1'b0;
         rep_q      <= 1'b0;
         over_q     <= 1'b0;
`ifdef GUESS_ONEHOT_CHECK_EN
         err_q      <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_SETUP: begin
               if (load_ships && (ship_map != '0)) begin
                  ships_q    <= ship_map;
                  ship_cnt_q <= popcnt(ship_map);
                  ready_q    <= 1'b1;
                  state_q    <= S_READY;
               end
            end
            S_READY: begin
               if (guess_valid) begin
                  guess_q <= guess;
                  ready_q <= 1'b0;
                  state_q <= S_EVAL;
               end
            end
            S_EVAL: begin
               valid_q <= 1'b1;
               state_q <= S_RESP;
`ifdef GUESS_ONEHOT_CHECK_EN
               err_q   <= bad_guess;
`endif
               if (bad_guess) begin
                  hit_q <= 1'b0;
                  rep_q <= 1'b0;
               end else if (is_rep) begin
                  hit_q <= 1'b0;
                  rep_q <= 1'b1;
               end else begin
                  hit_map_q  <= hit_map_q | g_hit;
                  miss_map_q <= miss_map_q | g_miss;
                  hit_cnt_q  <= hit_cnt_q + popcnt(g_hit);
                  hit_q      <= |g_hit;
                  rep_q      <= 1'b0;
               end
            end
            S_RESP: begin
               valid_q <= 1'b0;
               if (hit_cnt_q == ship_cnt_q) begin
                  over_q  <= 1'b1;
                  state_q <= S_OVER;
               end else begin
                  ready_q <= 1'b1;
                  state_q <= S_READY;
               end
            end
            S_OVER: begin
               state_q <= S_OVER;
            end
            default: begin
               state_q <= S_SETUP;
            end
         endcase
      end
   end

   assign guess_ready   = ready_q;
   assign result_valid  = valid_q;
   assign result_hit    = hit_q;
   assign result_repeat = rep_q;
   assign hit_map       = hit_map_q;
   assign miss_map      = miss_map_q;
   assign hit_count     = hit_cnt_q;
   assign game_over     = over_q;

endmodule

// File: tb/tb_guess_responder.sv
// Scoreboard bench for guess_responder: stimulus pushes expected results,
// a negedge monitor pops and compares on every result_valid.
module tb_guess_responder;

   localparam int CELLS = 28;
   localparam int CNT_W = 5;

   typedef struct packed {
      logic             hit;
      logic             rep;
      logic             err;
      logic [CELLS-1:0] hmap;
      logic [CELLS-1:0] mmap;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             load_ships = 1'b0;
   logic [CELLS-1:0] ship_map = '0;
   logic             guess_valid = 1'b0;
   logic [CELLS-1:0] guess = '0;
   logic             guess_ready;
   logic             result_valid;
   logic             result_hit;
   logic             result_repeat;
   logic             result_err;
   logic [CELLS-1:0] hit_map;
   logic [CELLS-1:0] miss_map;
   logic [CNT_W-1:0] hit_count;
   logic             game_over;

   int   errors = 0;
   int   checks = 0;
   int   n_results = 0;
   exp_t sb[$];

   guess_responder #(.CELLS(CELLS), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_ships   (load_ships),
      .ship_map     (ship_map),
      .guess_valid  (guess_valid),
      .guess        (guess),
      .guess_ready  (guess_ready),
      .result_valid (result_valid),
      .result_hit   (result_hit),
      .result_repeat(result_repeat),
      .result_err   (result_err),
      .hit_map      (hit_map),
      .miss_map     (miss_map),
      .hit_count    (hit_count),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic h, input logic r, input logic e,
                               input logic [CELLS-1:0] hm,
                               input logic [CELLS-1:0] mm,
                               input logic [CNT_W-1:0] c);
      exp_t x;
      x.hit = h; x.rep = r; x.err = e;
      x.hmap = hm; x.mmap = mm; x.cnt = c;
      return x;
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (!rst && result_valid) begin
         n_results++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got valid expected none");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", {result_hit, result_repeat, result_err,
                           hit_map, miss_map, hit_count}, e);
         end
      end
   end

   task automatic do_load(input logic [CELLS-1:0] m);
      @(negedge clk);
      load_ships = 1'b1;
      ship_map   = m;
      @(negedge clk);
      load_ships = 1'b0;
      ship_map   = '0;
   endtask

   task automatic send_guess(input string name, input logic [CELLS-1:0] g,
                             input exp_t e, input logic exp_over);
      int n;
      n = 0;
      while (!guess_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!guess_ready) begin
         chk({name, "_ready_timeout"}, 64'(guess_ready), 64'd1);
         return;
      end
      sb.push_back(e);
      guess       = g;
      guess_valid = 1'b1;
      @(posedge clk);
      #1;
      guess_valid = 1'b0;
      guess       = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk({name, "_result_seen"}, 64'(sb.size()), 64'd0);
      sb.delete();
      chk({name, "_over"}, {62'd0, game_over, guess_ready},
          {62'd0, exp_over, ~exp_over});
   endtask

   task automatic pulse_guesses(input int cyc);
      for (int i = 0; i < cyc; i++) begin
         @(negedge clk);
         guess_valid = 1'b1;
         guess       = CELLS'(1) << (i % CELLS);
      end
      @(negedge clk);
      guess_valid = 1'b0;
      guess       = '0;
      repeat (4) @(negedge clk);
   endtask

   task automatic check_idle(input string name);
      chk({name, "_flags"}, {58'd0, guess_ready, result_valid, result_hit,
                             result_repeat, result_err, game_over}, 64'd0);
      chk({name, "_maps"}, {3'd0, hit_map, miss_map, hit_count}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nr;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);

      // Empty ship map is ignored; guesses in SETUP produce nothing
      do_load('0);
      chk("zero_load_ready", 64'(guess_ready), 64'd0);
      nr = n_results;
      pulse_guesses(3);
      chk("setup_no_result", 64'(n_results), 64'(nr));
      chk("setup_ready", 64'(guess_ready), 64'd0);

      // Game 1: ships at cells 5 and 6
      do_load(28'h0000060);
      chk("load_ready", 64'(guess_ready), 64'd1);
      send_guess("g5", 28'h0000020,
                 mk(1, 0, 0, 28'h0000020, 28'h0, 5'd1), 1'b0);
      send_guess("g16", 28'h0010000,
                 mk(0, 0, 0, 28'h0000020, 28'h0010000, 5'd1), 1'b0);
      send_guess("rep16", 28'h0010000,
                 mk(0, 1, 0, 28'h0000020, 28'h0010000, 5'd1), 1'b0);
`ifdef GUESS_ONEHOT_CHECK_EN
      send_guess("multi", 28'h0000003,
                 mk(0, 0, 1, 28'h0000020, 28'h0010000, 5'd1), 1'b0);
      send_guess("zero", 28'h0,
                 mk(0, 0, 1, 28'h0000020, 28'h0010000, 5'd1), 1'b0);
`else
      send_guess("zero", 28'h0,
                 mk(0, 0, 0, 28'h0000020, 28'h0010000, 5'd1), 1'b0);
`endif
      send_guess("g6", 28'h0000040,
                 mk(1, 0, 0, 28'h0000060, 28'h0010000, 5'd2), 1'b1);

      // OVER: guesses ignored, maps frozen
      nr = n_results;
      pulse_guesses(3);
      chk("over_no_result", 64'(n_results), 64'(nr));
      chk("over_frozen", {3'd0, hit_map, miss_map, hit_count},
          {3'd0, 28'h0000060, 28'h0010000, 5'd2});
      chk("over_hold", {62'd0, game_over, guess_ready}, 64'd2);

      // Game 2: single ship at cell 0
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_idle("reset2");
      rst = 1'b0;
      do_load(28'h0000001);
`ifdef GUESS_ONEHOT_CHECK_EN
      send_guess("m3", 28'h0000003,
                 mk(0, 0, 1, 28'h0, 28'h0, 5'd0), 1'b0);
      send_guess("g0", 28'h0000001,
                 mk(1, 0, 0, 28'h0000001, 28'h0, 5'd1), 1'b1);
`else
      send_guess("m3", 28'h0000003,
                 mk(1, 0, 0, 28'h0000001, 28'h0000002, 5'd1), 1'b1);
`endif

      // Reset while a guess is in EVAL
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      do_load(28'h0000060);
      chk("rl_ready", 64'(guess_ready), 64'd1);
      guess       = 28'h0000020;
      guess_valid = 1'b1;
      @(posedge clk);
      #1;
      guess_valid = 1'b0;
      guess       = '0;
      rst         = 1'b1;
      nr          = n_results;
      @(negedge clk);
      check_idle("eval_rst");
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("eval_rst_no_result", 64'(n_results), 64'(nr));
      chk("eval_rst_setup", 64'(guess_ready), 64'd0);
      do_load(28'h0000060);
      chk("reload_ready", 64'(guess_ready), 64'd1);
      send_guess("post_rst", 28'h0000040,
                 mk(1, 0, 0, 28'h0000040, 28'h0, 5'd1), 1'b0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
